// File: rtl/data_mem_mmio.sv
// data_mem_mmio
// Data-side memory responder for the pipelined core. It provides a
// word-addressed RAM and a small MMIO window. The window holds a free-running
// cycle counter, a debug-output FIFO drained over valid/ready, and a sticky
// status/error register.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       asynchronous active-low reset (0 = in reset)
//   MemWriteM   store strobe for the memory-stage instruction
//   ALUOutM     byte address; bits [1:0] ignored (word access only)
//   WriteDataM  store data
//   ReadDataM   load data, combinational from ALUOutM
//   dbg_valid   debug FIFO non-empty
//   dbg_data    debug FIFO head entry (0 when empty)
//   dbg_ready   consumer accepts the head this cycle
//   err         overflow | badaddr (sticky flags)
//
// MMIO map (offsets from MMIO_BASE):
//   0x0 CYCLE   read: counter value, write: reload counter to 0
//   0x4 DBG_TX  read: 0, write: push WriteDataM into the debug FIFO
//   0x8 STATUS  read: {ovf, badaddr, 21'b0, full, count[7:0]}
//               write: bit31 clears ovf, bit30 clears badaddr

module data_mem_mmio #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        dbg_valid,
    output logic [31:0] dbg_data,
    input  logic        dbg_ready,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [29:0] BASE_W   = MMIO_BASE[31:2];
    localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Address decode (word granularity)
    // ------------------------------------------------------------------
    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic          sel_ram;
    logic          sel_cycle;
    logic          sel_dbg;
    logic          sel_status;
    logic          sel_unmapped;
    logic          unused_addr_lsbs;

    assign word_addr        = ALUOutM[31:2];
    assign ram_idx          = ALUOutM[AW+1:2];
    assign unused_addr_lsbs = ^ALUOutM[1:0];

    // RAM wins any overlap with the MMIO window so a misplaced base can
    // never shadow real memory.
    assign sel_ram      = (word_addr < 30'(DEPTH_WORDS));
    assign sel_cycle    = !sel_ram && (word_addr == BASE_W);
    assign sel_dbg      = !sel_ram && (word_addr == BASE_W + 30'd1);
    assign sel_status   = !sel_ram && (word_addr == BASE_W + 30'd2);
    assign sel_unmapped = !(sel_ram || sel_cycle || sel_dbg || sel_status);

    // ------------------------------------------------------------------
    // RAM (contents intentionally not reset)
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (MemWriteM && sel_ram) begin
            mem[ram_idx] <= WriteDataM;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter
    // ------------------------------------------------------------------
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else if (MemWriteM && sel_cycle) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Debug FIFO
    // ------------------------------------------------------------------
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          push_req;
    logic          push_ok;
    logic          pop;

    assign full      = (count == FULL_C);
    assign dbg_valid = (count != '0);
    assign pop       = dbg_valid && dbg_ready;
    assign push_req  = MemWriteM && sel_dbg;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign push_ok   = push_req && (!full || pop);
    assign dbg_data  = dbg_valid ? fifo_mem[rd_ptr] : 32'd0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= WriteDataM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags: a set event outranks a clear on the same edge
    // ------------------------------------------------------------------
    logic overflow;
    logic badaddr;
    logic ovf_set;
    logic ovf_clr;
    logic bad_set;
    logic bad_clr;

    assign ovf_set = push_req && !push_ok;
    assign ovf_clr = MemWriteM && sel_status && WriteDataM[31];
    assign bad_set = MemWriteM && sel_unmapped;
    assign bad_clr = MemWriteM && sel_status && WriteDataM[30];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            badaddr  <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (bad_set) begin
                badaddr <= 1'b1;
            end else if (bad_clr) begin
                badaddr <= 1'b0;
            end
        end
    end

    assign err = overflow | badaddr;

    // ------------------------------------------------------------------
    // Load mux (combinational, pre-edge state)
    // ------------------------------------------------------------------
    always_comb begin
        ReadDataM = 32'd0;
        if (sel_ram) begin
            ReadDataM = mem[ram_idx];
        end else if (sel_cycle) begin
            ReadDataM = cycle_cnt;
        end else if (sel_status) begin
            ReadDataM = {overflow, badaddr, 21'd0, full, 8'(count)};
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
module tb_data_mem_mmio;

    localparam logic [31:0] BASE   = 32'hFFFF_0000;
    localparam logic [31:0] A_CYC  = BASE;
    localparam logic [31:0] A_DBG  = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        dbg_valid;
    logic [31:0] dbg_data;
    logic        dbg_ready;
    logic        err;

    int passed = 0;
    int total  = 0;

    data_mem_mmio #(
        .DEPTH_WORDS(64),
        .FIFO_DEPTH (8),
        .MMIO_BASE  (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWriteM (MemWriteM),
        .ALUOutM   (ALUOutM),
        .WriteDataM(WriteDataM),
        .ReadDataM (ReadDataM),
        .dbg_valid (dbg_valid),
        .dbg_data  (dbg_data),
        .dbg_ready (dbg_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks follow a
    // further settle delay, so nothing is sampled on the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input logic [31:0] d);
        ALUOutM    = A_DBG;
        MemWriteM  = 1'b1;
        WriteDataM = d;
        tick();
        MemWriteM  = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        MemWriteM  = 1'b0;
        ALUOutM    = A_STAT;
        WriteDataM = 32'd0;
        dbg_ready  = 1'b0;
        #2;
        tick();
        tick();

        // Reset state
        #1;
        check("rst_dbg_valid", {31'd0, dbg_valid}, 32'd0);
        check("rst_dbg_data", dbg_data, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_status", ReadDataM, 32'd0);
        ALUOutM = A_CYC;
        #1;
        check("rst_cycle", ReadDataM, 32'd0);

        // Cycle counter free-runs from release
        reset = 1'b1;
        repeat (5) tick();
        #1;
        check("cycle_at_5", ReadDataM, 32'd5);
        repeat (4) tick();
        #1;
        check("cycle_at_9", ReadDataM, 32'd9);

        // RAM store/load, old value on same-cycle read
        ALUOutM = 32'h0; MemWriteM = 1'b1; WriteDataM = 32'hCAFE_0000;
        tick();
        ALUOutM = 32'h10; WriteDataM = 32'h1111_1111;
        tick();
        WriteDataM = 32'hDEAD_BEEF;
        #1;
        check("ram_same_cycle_old", ReadDataM, 32'h1111_1111);
        tick();
        MemWriteM = 1'b0;
        #1;
        check("ram_next_cycle_new", ReadDataM, 32'hDEAD_BEEF);
        ALUOutM = 32'h13;
        #1;
        check("ram_ignore_lsbs", ReadDataM, 32'hDEAD_BEEF);
        ALUOutM = 32'h0;
        #1;
        check("ram_word0", ReadDataM, 32'hCAFE_0000);

        // Cycle counter reload and wrap
        ALUOutM = A_CYC; MemWriteM = 1'b1; WriteDataM = 32'h55;
        tick();
        MemWriteM = 1'b0;
        #1;
        check("cycle_reload", ReadDataM, 32'd0);
        repeat (3) tick();
        #1;
        check("cycle_plus3", ReadDataM, 32'd3);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        check("cycle_forced", ReadDataM, 32'hFFFF_FFFF);
        release dut.cycle_cnt;
        tick();
        #1;
        check("cycle_wrap", ReadDataM, 32'd0);

        // FIFO overflow with consumer stalled
        for (int i = 1; i <= 9; i++) push(32'(i));
        ALUOutM = A_STAT;
        #1;
        check("status_ovf_full", ReadDataM, 32'h8000_0108);
        check("err_ovf", {31'd0, err}, 32'd1);
        check("head_after_ovf", dbg_data, 32'd1);
        ALUOutM = A_DBG;
        #1;
        check("dbg_tx_reads_0", ReadDataM, 32'd0);
        dbg_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_valid", {31'd0, dbg_valid}, 32'd1);
            check("drain_data", dbg_data, 32'(i));
            tick();
            #1;
        end
        check("drained_valid", {31'd0, dbg_valid}, 32'd0);
        check("drained_data", dbg_data, 32'd0);
        dbg_ready = 1'b0;
        ALUOutM = A_STAT; MemWriteM = 1'b1; WriteDataM = 32'h8000_0000;
        tick();
        MemWriteM = 1'b0;
        #1;
        check("ovf_cleared_status", ReadDataM, 32'd0);
        check("ovf_cleared_err", {31'd0, err}, 32'd0);

        // Push and pop on the same edge while full
        for (int i = 0; i < 8; i++) push(32'h100 + 32'(i));
        dbg_ready = 1'b1;
        push(32'hAA);
        dbg_ready = 1'b0;
        ALUOutM = A_STAT;
        #1;
        check("full_pushpop_status", ReadDataM, 32'h0000_0108);
        check("full_pushpop_err", {31'd0, err}, 32'd0);
        dbg_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("pp_drain", dbg_data, (i == 8) ? 32'hAA : 32'h100 + 32'(i));
            tick();
            #1;
        end
        check("pp_empty", {31'd0, dbg_valid}, 32'd0);
        dbg_ready = 1'b0;

        // Unmapped accesses
        ALUOutM = 32'h8000_0000;
        #1;
        check("unmapped_read", ReadDataM, 32'd0);
        tick();
        #1;
        check("unmapped_read_noflag", {31'd0, err}, 32'd0);
        MemWriteM = 1'b1; WriteDataM = 32'h1234_5678;
        tick();
        MemWriteM = 1'b0;
        #1;
        check("badaddr_err", {31'd0, err}, 32'd1);
        ALUOutM = A_STAT;
        #1;
        check("badaddr_status", ReadDataM, 32'h4000_0000);
        ALUOutM = 32'h0;
        #1;
        check("ram0_unchanged", ReadDataM, 32'hCAFE_0000);
        ALUOutM = 32'h10;
        #1;
        check("ram10_unchanged", ReadDataM, 32'hDEAD_BEEF);
        ALUOutM = A_STAT; MemWriteM = 1'b1; WriteDataM = 32'h4000_0000;
        tick();
        MemWriteM = 1'b0;
        #1;
        check("badaddr_clear_err", {31'd0, err}, 32'd0);
        check("badaddr_clear_status", ReadDataM, 32'd0);
        ALUOutM = BASE + 32'hC; MemWriteM = 1'b1;
        tick();
        MemWriteM = 1'b0;
        ALUOutM = A_STAT;
        #1;
        check("window_hole_badaddr", ReadDataM, 32'h4000_0000);

        // Asynchronous reset with entries held
        for (int i = 0; i < 5; i++) push(32'h200 + 32'(i));
        ALUOutM = A_STAT;
        #1;
        check("pre_reset_status", ReadDataM, 32'h4000_0005);
        reset = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, dbg_valid}, 32'd0);
        check("async_rst_data", dbg_data, 32'd0);
        check("async_rst_status", ReadDataM, 32'd0);
        check("async_rst_err", {31'd0, err}, 32'd0);
        ALUOutM = A_CYC;
        #1;
        check("async_rst_cycle", ReadDataM, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Data-side memory responder for the pipelined core. It serves the core's memory-stage accesses (MemWriteM, ALUOutM, WriteDataM in; ReadDataM out) with a word-addressed RAM and a small MMIO window. The window holds a cycle counter, an 8-entry debug-output FIFO drained over a valid/ready port, and a status/error register. It sits beside the core at top level, in place of a plain data RAM.

## Interface
Parameters:
- DEPTH_WORDS, 64, number of 32-bit RAM words (power of 2); RAM covers byte addresses 0 .. 4*DEPTH_WORDS-1
- FIFO_DEPTH, 8, debug FIFO entries (power of 2, 2..128)
- MMIO_BASE, 32'hFFFF_0000, base of the 64 KiB MMIO window

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- MemWriteM  in  1  store strobe for the current memory-stage instruction
- ALUOutM  in  32  byte address; bits [1:0] ignored (word access only)
- WriteDataM  in  32  store data
- ReadDataM  out  32  load data, combinational from ALUOutM
- dbg_valid  out  1  FIFO non-empty
- dbg_data  out  32  FIFO head entry
- dbg_ready  in  1  consumer accepts head this cycle
- err  out  1  OR of the sticky overflow and badaddr flags

## Operation
- Decode on ALUOutM[31:2]: RAM if address < 4*DEPTH_WORDS; CYCLE at MMIO_BASE+0x0; DBG_TX at +0x4; STATUS at +0x8; everything else is unmapped.
- RAM read: ReadDataM = mem[ALUOutM[log2(DEPTH_WORDS)+1:2]]. RAM write: on the edge with MemWriteM=1. RAM contents are not reset.
- CYCLE: free-running 32-bit up-counter that wraps 0xFFFF_FFFF -> 0. A read returns the current value. A write of any data loads 0 at that edge; the counter increments again from the following edge.
- DBG_TX: a write pushes WriteDataM. The push is accepted if count < FIFO_DEPTH, or if a pop happens on the same edge. Otherwise the data is dropped and sticky overflow is set. A read returns 0.
- Pop occurs on the edge where dbg_valid && dbg_ready. dbg_data is the head; its value is don't-care when empty, but the RTL drives 0.
- Simultaneous push and pop: count is unchanged, the head advances, and the new entry goes to the tail. On an empty FIFO, a push does not pop in the same cycle because dbg_valid=0.
- STATUS read value: bit31 overflow, bit30 badaddr, bit8 full (count==FIFO_DEPTH), bits[7:0] count. All other bits are 0.
- STATUS write: WriteDataM[31]=1 clears overflow; WriteDataM[30]=1 clears badaddr. If a set event and a clear land on the same edge, the set wins. Other bits are ignored.
- Unmapped access: a read returns 0. A write is ignored and sets sticky badaddr. Reads never set badaddr, because the core drives ALUOutM every cycle.
- err = overflow | badaddr, registered flags driven straight out.
- Internal state: FIFO rd/wr pointers (log2(FIFO_DEPTH) bits) plus a count register (log2(FIFO_DEPTH)+1 bits). Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (reset=0, asynchronous) clears CYCLE, FIFO pointers, count, overflow and badaddr. Resulting outputs: dbg_valid=0, dbg_data=0, err=0. ReadDataM follows decode: 0 for MMIO reads, RAM content unaffected.
- Reset deassertion is synchronized externally. The first post-reset edge increments CYCLE to 1.
- Reset asserted mid-operation discards FIFO contents immediately; any in-flight push on that edge is lost.
- Load latency is 0 cycles (combinational, same cycle as ALUOutM). Store and MMIO side-effects take effect at the edge ending the cycle.
- A same-cycle read of an address being written returns the old value; the next cycle returns the new value.
- STATUS count/full/flags read the pre-edge state.
- dbg_valid rises in the cycle after the first accepted push. It falls in the cycle after the pop that empties the FIFO, unless a push lands on that same edge.
- Full throughput: one push and one pop per cycle sustained.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10 and load 0x10 in the next cycle -> ReadDataM=0xDEADBEEF. A load of 0x10 in the same cycle as the store -> old value.
- Read CYCLE at cycles 5 and 9 after reset -> difference of 4. Write CYCLE, read it 3 cycles later -> 3. Force the counter to 0xFFFF_FFFF and clock once -> 0.
- With dbg_ready=0, push 9 words 1..9 -> STATUS=0x8000_0108, err=1, dbg_data=1. Then set dbg_ready=1 -> dbg_data sequence 1..8, followed by dbg_valid=0.
- With the FIFO full, push 0xAA and pop in the same cycle -> count stays 8, no overflow, 0xAA emerges last.
- Store to 0x8000_0000 -> badaddr=1, err=1, RAM unchanged. A load from the same address -> 0 and no flag. STATUS write 0x4000_0000 -> badaddr cleared, err=0.
- Assert reset with 5 FIFO entries held -> dbg_valid=0, count=0 and CYCLE=0 immediately, without waiting for a clock edge.
